int_to_rec_fn_iter: RTL and testbench

INT_TO_REC_FN_ITER -- requirements
Module: int_to_rec_fn_iter

---
 rtl/int_to_rec_fn_iter.sv | 134 +++++++++++++
 tb/tb_int_to_rec_fn_iter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_to_rec_fn_iter.sv
// Iterative 32-bit integer to recoded e8/s24 float converter.
// One request at a time: the magnitude is normalised a byte or a bit per
// cycle, rounded in a single cycle, then held until the consumer takes it.
module int_to_rec_fn_iter (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_bits_in,
   input  logic        in_bits_signedIn,
   input  logic [2:0]  in_bits_roundingMode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [32:0] out_bits_out,
   output logic [4:0]  out_bits_exceptionFlags
);

   typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

   localparam logic [2:0] RM_NEAR_EVEN   = 3'd0;
   localparam logic [2:0] RM_MIN_MAG     = 3'd1;
   localparam logic [2:0] RM_MIN         = 3'd2;
   localparam logic [2:0] RM_MAX         = 3'd3;
   localparam logic [2:0] RM_NEAR_MAXMAG = 3'd4;
   localparam logic [2:0] RM_ODD         = 3'd6;

   state_t      state;
   logic [31:0] mag;
   logic [4:0]  lzCount;
   logic        sign;
   logic [2:0]  roundMode;
   logic [32:0] outBits;
   logic [4:0]  outFlags;

   // Operand sign and magnitude at the point of acceptance.
   logic        inSign;
   logic [31:0] inMag;
   assign inSign = in_bits_signedIn & in_bits_in[31];
   assign inMag  = inSign ? (~in_bits_in + 32'd1) : in_bits_in;

   // Rounding datapath, valid while the normalised magnitude sits in mag.
   // mag[31] is always set here, so the significand overflows to 2^24
   // exactly when the 23 fraction bits are all ones and we increment.
   logic        guardBit;
   logic        stickyBit;
   logic        inexact;
   logic        roundInc;
   logic        roundCarry;
   logic [22:0] fractRnd;
   logic [22:0] fractOut;
   logic [8:0]  expOut;

   // Rounding decision, increment and exponent for the ROUND cycle.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      roundInc  = 1'b0;
      guardBit  = mag[7];
      stickyBit = |mag[6:0];
      inexact   = guardBit | stickyBit;
      case (roundMode)
         RM_NEAR_EVEN:   roundInc = guardBit & (stickyBit | mag[8]);
         RM_NEAR_MAXMAG: roundInc = guardBit;
         RM_MIN:         roundInc = sign & inexact;
         RM_MAX:         roundInc = ~sign & inexact;
         RM_MIN_MAG:     roundInc = 1'b0;
         default:        roundInc = 1'b0;
      endcase
      roundCarry = roundInc & (&mag[30:8]);
      fractRnd   = mag[30:8] + {22'd0, roundInc};
      fractOut   = {fractRnd[22:1],
                    fractRnd[0] | ((roundMode == RM_ODD) & inexact)};
      expOut     = 9'h100 + {4'd0, 5'd31 - lzCount} + {8'd0, roundCarry};
   end

   // Control FSM and datapath registers; reset aborts any operation.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      if (reset) begin
         state     <= IDLE;
         mag       <= 32'd0;
         lzCount   <= 5'd0;
         sign      <= 1'b0;
         roundMode <= 3'd0;
         outBits   <= 33'd0;
         outFlags  <= 5'd0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  roundMode <= in_bits_roundingMode;
                  sign      <= inSign;
                  mag       <= inMag;
                  lzCount   <= 5'd0;
                  if (inMag != 32'd0) begin
                     state <= NORM;
                  end else begin
                     outBits  <= 33'd0;
                     outFlags <= 5'd0;
                     state    <= DONE;
                  end
               end
            end
            NORM: begin
               if (mag[31:24] == 8'd0) begin
                  mag     <= mag << 8;
                  lzCount <= lzCount + 5'd8;
               end else if (!mag[31]) begin
                  mag     <= mag << 1;
                  lzCount <= lzCount + 5'd1;
               end else begin
                  state <= ROUND;
               end
            end
            ROUND: begin
               outBits  <= {sign, expOut, fractOut};
               outFlags <= {4'b0000, inexact};
               state    <= DONE;
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready                = (state == IDLE);
   assign out_valid               = (state == DONE);
   assign out_bits_out            = outBits;
   assign out_bits_exceptionFlags = outFlags;

endmodule

// File: tb/tb_int_to_rec_fn_iter.sv
// Directed self-checking bench for int_to_rec_fn_iter.
module tb_int_to_rec_fn_iter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_bits_in = 32'd0;
   logic        in_bits_signedIn = 1'b0;
   logic [2:0]  in_bits_roundingMode = 3'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [32:0] out_bits_out;
   logic [4:0]  out_bits_exceptionFlags;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] a;
      logic        s;
      logic [2:0]  m;
      logic [32:0] o;
      logic [4:0]  f;
      int          lat;
   } vec_t;

   int_to_rec_fn_iter dut (
      .clock                   (clock),
      .reset                   (reset),
      .in_valid                (in_valid),
      .in_ready                (in_ready),
      .in_bits_in              (in_bits_in),
      .in_bits_signedIn        (in_bits_signedIn),
      .in_bits_roundingMode    (in_bits_roundingMode),
      .out_valid               (out_valid),
      .out_ready               (out_ready),
      .out_bits_out            (out_bits_out),
      .out_bits_exceptionFlags (out_bits_exceptionFlags)
   );

   always #5 clock = ~clock;

   // Issue one request and wait for its result. Latency counts rising edges
   // from the accept edge (inclusive) to the edge that raises out_valid.
   task automatic run_op(input logic [31:0] a, input logic s, input logic [2:0] m,
                         output logic [32:0] o, output logic [4:0] f,
                         output int lat, output logic rdy);
      @(negedge clock);
      in_bits_in = a;
      in_bits_signedIn = s;
      in_bits_roundingMode = m;
      in_valid = 1'b1;
      rdy = in_ready;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 64) begin
         @(posedge clock);
         #1;
         lat++;
      end
      o = out_bits_out;
      f = out_bits_exceptionFlags;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
      end
      checks++;
      if (out_bits_out !== 33'd0 || out_bits_exceptionFlags !== 5'd0) begin
         failures++;
         $display("FAIL reset_out: out=%h flags=%h want 0/0", out_bits_out, out_bits_exceptionFlags);
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_vectors();
      vec_t vecs[19];
      logic [32:0] o;
      logic [4:0]  f;
      int          lat;
      logic        rdy;
      vecs[0]  = '{32'h00000001, 1'b1, 3'd0, 33'h0_8000_0000, 5'h00, 13};
      vecs[1]  = '{32'hFFFFFFFF, 1'b1, 3'd0, 33'h1_8000_0000, 5'h00, 13};
      vecs[2]  = '{32'h80000000, 1'b1, 3'd0, 33'h1_8F80_0000, 5'h00, 3};
      vecs[3]  = '{32'hFFFFFFFF, 1'b0, 3'd0, 33'h0_9000_0000, 5'h01, 3};
      vecs[4]  = '{32'hFFFFFFFF, 1'b0, 3'd1, 33'h0_8FFF_FFFF, 5'h01, 3};
      vecs[5]  = '{32'h00000000, 1'b1, 3'd0, 33'h0_0000_0000, 5'h00, 1};
      vecs[6]  = '{32'h80000000, 1'b0, 3'd0, 33'h0_8F80_0000, 5'h00, 3};
      vecs[7]  = '{32'h01000001, 1'b0, 3'd0, 33'h0_8C00_0000, 5'h01, 10};
      vecs[8]  = '{32'h01000001, 1'b0, 3'd4, 33'h0_8C00_0001, 5'h01, 10};
      vecs[9]  = '{32'h01000001, 1'b0, 3'd6, 33'h0_8C00_0001, 5'h01, 10};
      vecs[10] = '{32'h01000003, 1'b0, 3'd0, 33'h0_8C00_0002, 5'h01, 10};
      vecs[11] = '{32'hFEFFFFFF, 1'b1, 3'd2, 33'h1_8C00_0001, 5'h01, 10};
      vecs[12] = '{32'hFEFFFFFF, 1'b1, 3'd3, 33'h1_8C00_0000, 5'h01, 10};
      vecs[13] = '{32'h01000001, 1'b0, 3'd3, 33'h0_8C00_0001, 5'h01, 10};
      vecs[14] = '{32'hFFFFFFFF, 1'b0, 3'd5, 33'h0_8FFF_FFFF, 5'h01, 3};
      vecs[15] = '{32'h00000100, 1'b0, 3'd0, 33'h0_8400_0000, 5'h00, 12};
      vecs[16] = '{32'h7FFFFFFF, 1'b1, 3'd0, 33'h0_8F80_0000, 5'h01, 4};
      vecs[17] = '{32'hFFFFFFFF, 1'b0, 3'd2, 33'h0_8FFF_FFFF, 5'h01, 3};
      vecs[18] = '{32'hFFFFFFFF, 1'b0, 3'd3, 33'h0_9000_0000, 5'h01, 3};
      for (int i = 0; i < 19; i++) begin
         run_op(vecs[i].a, vecs[i].s, vecs[i].m, o, f, lat, rdy);
         checks++;
         if (rdy !== 1'b1) begin
            failures++;
            $display("FAIL vec%0d ready: in_ready=%b want 1", i, rdy);
         end
         checks++;
         if (o !== vecs[i].o) begin
            failures++;
            $display("FAIL vec%0d out: got %h want %h", i, o, vecs[i].o);
         end
         checks++;
         if (f !== vecs[i].f) begin
            failures++;
            $display("FAIL vec%0d flags: got %h want %h", i, f, vecs[i].f);
         end
         checks++;
         if (lat != vecs[i].lat) begin
            failures++;
            $display("FAIL vec%0d latency: got %0d want %0d", i, lat, vecs[i].lat);
         end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      int bad;
      @(negedge clock);
      out_ready = 1'b0;
      in_bits_in = 32'h80000000;
      in_bits_signedIn = 1'b1;
      in_bits_roundingMode = 3'd0;
      in_valid = 1'b1;
      @(posedge clock);
      #1;
      // Second request stays pending while the first is in flight.
      in_bits_in = 32'h00000001;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 64) begin
         @(posedge clock);
         #1;
         lat++;
      end
      checks++;
      if (lat != 3) begin
         failures++;
         $display("FAIL bp_first_latency: got %0d want 3", lat);
      end
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock);
         #1;
         if (out_bits_out !== 33'h1_8F80_0000 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL bp_hold: %0d bad cycles out=%h valid=%b ready=%b want 0", bad, out_bits_out, out_valid, in_ready);
      end
      @(negedge clock);
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_release: valid=%b ready=%b want 0/1", out_valid, in_ready);
      end
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 64) begin
         @(posedge clock);
         #1;
         lat++;
      end
      checks++;
      if (lat != 13 || out_bits_out !== 33'h0_8000_0000) begin
         failures++;
         $display("FAIL bp_second: out=%h lat=%0d want 080000000/13", out_bits_out, lat);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset_abort();
      logic [32:0] o;
      logic [4:0]  f;
      int          lat;
      logic        rdy;
      int          seen;
      // Abort during NORM.
      @(negedge clock);
      in_bits_in = 32'h00000001;
      in_bits_signedIn = 1'b1;
      in_bits_roundingMode = 3'd0;
      in_valid = 1'b1;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_norm: ready=%b valid=%b want 1/0", in_ready, out_valid);
      end
      @(negedge clock);
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 16; i++) begin
         @(posedge clock);
         #1;
         if (out_valid === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL rst_norm_noresult: out_valid cycles=%0d want 0", seen);
      end
      run_op(32'hFFFFFFFF, 1'b0, 3'd0, o, f, lat, rdy);
      checks++;
      if (o !== 33'h0_9000_0000 || f !== 5'h01 || lat != 3) begin
         failures++;
         $display("FAIL rst_after: out=%h flags=%h lat=%0d want 090000000/01/3", o, f, lat);
      end
      // Abort in DONE with the consumer stalled.
      @(negedge clock);
      out_ready = 1'b0;
      in_bits_in = 32'h80000000;
      in_bits_signedIn = 1'b1;
      in_valid = 1'b1;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("FAIL rst_done_pre: valid=%b want 1", out_valid);
      end
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bits_out !== 33'd0) begin
         failures++;
         $display("FAIL rst_done: valid=%b ready=%b out=%h want 0/1/0", out_valid, in_ready, out_bits_out);
      end
      // Reset beats a request presented in the same cycle.
      @(negedge clock);
      in_bits_in = 32'h00000005;
      in_valid = 1'b1;
      @(posedge clock);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL rst_priority: ready=%b want 1", in_ready);
      end
      @(negedge clock);
      in_valid = 1'b0;
      reset = 1'b0;
      out_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_backpressure();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
